// File: rtl/mod_cache_arbiter.sv
// mod_cache_arbiter: round-robin arbiter sharing one memory port between an
// instruction cache (port 0) and a data cache (port 1), one transaction at a time.
module mod_cache_arbiter #(
  parameter int REQ_WIDTH  = 64,
  parameter int RESP_WIDTH = 512,
  parameter int TAG_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REQ_WIDTH-1:0]  i_req,
  input  logic [TAG_WIDTH-1:0]  i_reqtag,
  input  logic                  i_reqcyc,
  output logic                  i_reqack,
  output logic [RESP_WIDTH-1:0] i_resp,
  output logic [TAG_WIDTH-1:0]  i_resptag,
  output logic                  i_respcyc,
  input  logic                  i_respack,
  input  logic [REQ_WIDTH-1:0]  d_req,
  input  logic [TAG_WIDTH-1:0]  d_reqtag,
  input  logic                  d_reqcyc,
  output logic                  d_reqack,
  output logic [RESP_WIDTH-1:0] d_resp,
  output logic [TAG_WIDTH-1:0]  d_resptag,
  output logic                  d_respcyc,
  input  logic                  d_respack,
  output logic [REQ_WIDTH-1:0]  m_req,
  output logic [TAG_WIDTH-1:0]  m_reqtag,
  output logic                  m_reqcyc,
  input  logic                  m_reqack,
  input  logic [RESP_WIDTH-1:0] m_resp,
  input  logic [TAG_WIDTH-1:0]  m_resptag,
  input  logic                  m_respcyc,
  output logic                  m_respack
);
  typedef enum logic [1:0] {IDLE, MREQ, MWAIT, CRESP} state_t;
  state_t                state_q, state_d;
  logic                  owner_q, owner_d, last_q, last_d, win;
  logic [REQ_WIDTH-1:0]  m_req_q, m_req_d;
  logic [TAG_WIDTH-1:0]  m_reqtag_q, m_reqtag_d;
  logic                  m_reqcyc_q, m_reqcyc_d;
  logic                  i_reqack_q, i_reqack_d, d_reqack_q, d_reqack_d;
  logic [RESP_WIDTH-1:0] i_resp_q, i_resp_d, d_resp_q, d_resp_d;
  logic [TAG_WIDTH-1:0]  i_resptag_q, i_resptag_d, d_resptag_q, d_resptag_d;
  logic                  i_respcyc_q, i_respcyc_d, d_respcyc_q, d_respcyc_d;
  assign m_req     = m_req_q;
  assign m_reqtag  = m_reqtag_q;
  assign m_reqcyc  = m_reqcyc_q;
  assign i_reqack  = i_reqack_q;
  assign d_reqack  = d_reqack_q;
  assign i_resp    = i_resp_q;
  assign d_resp    = d_resp_q;
  assign i_resptag = i_resptag_q;
  assign d_resptag = d_resptag_q;
  assign i_respcyc = i_respcyc_q;
  assign d_respcyc = d_respcyc_q;
  assign m_respack = m_respcyc && state_q == MWAIT;
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    m_req_d     = m_req_q;
    m_reqtag_d  = m_reqtag_q;
    m_reqcyc_d  = m_reqcyc_q;
    i_reqack_d  = 1'b0;
    d_reqack_d  = 1'b0;
    i_resp_d    = i_resp_q;
    d_resp_d    = d_resp_q;
    i_resptag_d = i_resptag_q;
    d_resptag_d = d_resptag_q;
    i_respcyc_d = i_respcyc_q;
    d_respcyc_d = d_respcyc_q;
    // on contention the requester that did not win last time gets the grant
    win = (i_reqcyc && d_reqcyc) ? ~last_q : d_reqcyc;
    case (state_q)
      IDLE: if (i_reqcyc || d_reqcyc) begin
        owner_d    = win;
        last_d     = win;
        m_req_d    = win ? d_req : i_req;
        m_reqtag_d = win ? d_reqtag : i_reqtag;
        m_reqcyc_d = 1'b1;
        state_d    = MREQ;
      end
      MREQ: if (m_reqack) begin
        m_reqcyc_d = 1'b0;
        i_reqack_d = ~owner_q;
        d_reqack_d = owner_q;
        state_d    = MWAIT;
      end
      MWAIT: if (m_respcyc) begin
        if (owner_q) begin
          d_resp_d    = m_resp;
          d_resptag_d = m_resptag;
          d_respcyc_d = 1'b1;
        end else begin
          i_resp_d    = m_resp;
          i_resptag_d = m_resptag;
          i_respcyc_d = 1'b1;
        end
        state_d = CRESP;
      end
      CRESP: if (owner_q ? d_respack : i_respack) begin
        i_respcyc_d = 1'b0;
        d_respcyc_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      m_req_q     <= '0;
      m_reqtag_q  <= '0;
      m_reqcyc_q  <= 1'b0;
      i_reqack_q  <= 1'b0;
      d_reqack_q  <= 1'b0;
      i_resp_q    <= '0;
      d_resp_q    <= '0;
      i_resptag_q <= '0;
      d_resptag_q <= '0;
      i_respcyc_q <= 1'b0;
      d_respcyc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      m_req_q     <= m_req_d;
      m_reqtag_q  <= m_reqtag_d;
      m_reqcyc_q  <= m_reqcyc_d;
      i_reqack_q  <= i_reqack_d;
      d_reqack_q  <= d_reqack_d;
      i_resp_q    <= i_resp_d;
      d_resp_q    <= d_resp_d;
      i_resptag_q <= i_resptag_d;
      d_resptag_q <= d_resptag_d;
      i_respcyc_q <= i_respcyc_d;
      d_respcyc_q <= d_respcyc_d;
    end
  end
endmodule

// File: tb/tb_mod_cache_arbiter.sv
// tb_mod_cache_arbiter: randomized transaction-level checks of mod_cache_arbiter
// against a round-robin reference model.
module tb_mod_cache_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic [63:0] i_req, d_req, m_req;
  logic [12:0] i_reqtag, d_reqtag, m_reqtag, i_resptag, d_resptag, m_resptag;
  logic i_reqcyc, d_reqcyc, m_reqcyc, i_reqack, d_reqack, m_reqack;
  logic [511:0] i_resp, d_resp, m_resp;
  logic i_respcyc, d_respcyc, m_respcyc, i_respack, d_respack, m_respack;
  int n_tests = 0, n_fail = 0;
  logic exp_last;
  logic [511:0] exp_i_resp, exp_d_resp;
  logic [12:0] exp_i_tag, exp_d_tag;
  always #5 clk = ~clk;
  mod_cache_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_reqtag(i_reqtag), .i_reqcyc(i_reqcyc), .i_reqack(i_reqack),
    .i_resp(i_resp), .i_resptag(i_resptag), .i_respcyc(i_respcyc), .i_respack(i_respack),
    .d_req(d_req), .d_reqtag(d_reqtag), .d_reqcyc(d_reqcyc), .d_reqack(d_reqack),
    .d_resp(d_resp), .d_resptag(d_resptag), .d_respcyc(d_respcyc), .d_respack(d_respack),
    .m_req(m_req), .m_reqtag(m_reqtag), .m_reqcyc(m_reqcyc), .m_reqack(m_reqack),
    .m_resp(m_resp), .m_resptag(m_resptag), .m_respcyc(m_respcyc), .m_respack(m_respack)
  );
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic check_zero();
    check("rst_m_reqcyc", m_reqcyc, 0);
    check("rst_m_req", m_req, 0);
    check("rst_m_reqtag", m_reqtag, 0);
    check("rst_reqack", {i_reqack, d_reqack}, 0);
    check("rst_respcyc", {i_respcyc, d_respcyc}, 0);
    check("rst_i_resp", i_resp, 0);
    check("rst_d_resp", d_resp, 0);
    check("rst_resptag", {i_resptag, d_resptag}, 0);
    check("rst_m_respack", m_respack, 0);
  endtask
  task automatic check_resp(input logic w);
    check("i_respcyc", i_respcyc, !w);
    check("d_respcyc", d_respcyc, w);
    check("i_resp", i_resp, exp_i_resp);
    check("d_resp", d_resp, exp_d_resp);
    check("i_resptag", i_resptag, exp_i_tag);
    check("d_resptag", d_resptag, exp_d_tag);
    check("cresp_no_reqack", {i_reqack, d_reqack}, 0);
  endtask
  // One full transaction starting from an idle arbiter, with the given delays.
  task automatic txn(input logic want_i, input logic want_d, input int ack_dly, input int resp_dly,
                     input int rack_dly, input logic spurious, input logic abort,
                     input logic [63:0] ireq, input logic [12:0] itag);
    logic w;
    logic [63:0] wreq;
    logic [12:0] wtag, btag;
    logic [511:0] blk;
    i_req = ireq;
    i_reqtag = itag;
    d_req = {$urandom, $urandom};
    d_reqtag = 13'($urandom);
    i_reqcyc = want_i;
    d_reqcyc = want_d;
    m_reqack = 1'b0;
    m_respcyc = spurious;
    m_resp = rand_blk();
    m_resptag = 13'($urandom);
    w = (want_i && want_d) ? !exp_last : want_d;
    wreq = w ? d_req : i_req;
    wtag = w ? d_reqtag : i_reqtag;
    @(negedge clk);
    check("grant_cyc", m_reqcyc, 1);
    check("grant_req", m_req, wreq);
    check("grant_tag", m_reqtag, wtag);
    check("grant_no_reqack", {i_reqack, d_reqack}, 0);
    check("grant_no_respcyc", {i_respcyc, d_respcyc}, 0);
    check("grant_respack", m_respack, 0);
    check("grant_i_resp", i_resp, exp_i_resp);
    check("grant_d_resp", d_resp, exp_d_resp);
    exp_last = w;
    m_respcyc = 1'b0;
    if (w) d_reqcyc = 1'b0; else i_reqcyc = 1'b0;
    repeat (ack_dly) begin
      @(negedge clk);
      check("stall_cyc", m_reqcyc, 1);
      check("stall_req", m_req, wreq);
      check("stall_tag", m_reqtag, wtag);
      check("stall_no_reqack", {i_reqack, d_reqack}, 0);
    end
    m_reqack = 1'b1;
    @(negedge clk);
    m_reqack = 1'b0;
    check("mreq_drop", m_reqcyc, 0);
    check("reqack_owner", w ? d_reqack : i_reqack, 1);
    check("reqack_other", w ? i_reqack : d_reqack, 0);
    if (abort) begin
      m_respcyc = 1'b1;
      #2 reset = 1'b0;
      #1 check_zero();
      exp_i_resp = '0;
      exp_d_resp = '0;
      exp_i_tag = '0;
      exp_d_tag = '0;
      exp_last = 1'b1;
      return;
    end
    repeat (resp_dly) begin
      m_reqack = 1'($urandom);
      @(negedge clk);
      check("mwait_quiet", {i_reqack, d_reqack, i_respcyc, d_respcyc, m_reqcyc}, 0);
    end
    blk = rand_blk();
    btag = 13'($urandom);
    m_resp = blk;
    m_resptag = btag;
    m_respcyc = 1'b1;
    m_reqack = 1'($urandom);
    #1 check("respack_mwait", m_respack, 1);
    @(negedge clk);
    m_respcyc = 1'b0;
    if (w) begin
      exp_d_resp = blk;
      exp_d_tag = btag;
    end else begin
      exp_i_resp = blk;
      exp_i_tag = btag;
    end
    check_resp(w);
    repeat (rack_dly) begin
      m_respcyc = 1'($urandom);
      m_resp = rand_blk();
      m_reqack = 1'($urandom);
      #1 check("respack_cresp", m_respack, 0);
      @(negedge clk);
      check_resp(w);
      check("cresp_no_mreq", m_reqcyc, 0);
    end
    m_respcyc = 1'b0;
    m_reqack = 1'b0;
    if (w) d_respack = 1'b1; else i_respack = 1'b1;
    @(negedge clk);
    i_respack = 1'b0;
    d_respack = 1'b0;
    check("respcyc_drop", {i_respcyc, d_respcyc}, 0);
    check("idle_no_mreq", m_reqcyc, 0);
    i_reqcyc = 1'b0;
    d_reqcyc = 1'b0;
  endtask
  initial begin
    logic [1:0] want;
    logic [511:0] blk;
    {i_req, d_req, i_reqtag, d_reqtag, i_reqcyc, d_reqcyc, i_respack, d_respack} = '0;
    {m_reqack, m_resp, m_resptag, m_respcyc} = '0;
    exp_last = 1'b1;
    {exp_i_resp, exp_d_resp, exp_i_tag, exp_d_tag} = '0;
    #1 reset = 1'b0;
    #2 check_zero();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    txn(1, 0, 2, 4, 1, 0, 0, 64'h1000, 13'h5);
    txn(1, 1, 1, 1, 0, 0, 1, {$urandom, $urandom}, 13'($urandom));
    @(negedge clk);
    reset = 1'b1;
    txn(1, 1, 0, 2, 0, 1, 0, {$urandom, $urandom}, 13'($urandom));
    repeat (3) txn(1, 1, 1, 1, 1, 0, 0, {$urandom, $urandom}, 13'($urandom));
    txn(0, 1, 10, 1, 0, 0, 0, 64'h0, 13'h0);
    txn(1, 1, 1, 1, 7, 0, 0, {$urandom, $urandom}, 13'($urandom));
    blk = rand_blk();
    m_resp = blk;
    m_respcyc = 1'b1;
    #1 check("spurious_respack", m_respack, 0);
    @(negedge clk);
    m_respcyc = 1'b0;
    check("spurious_respcyc", {i_respcyc, d_respcyc}, 0);
    check("spurious_i_resp", i_resp, exp_i_resp);
    check("spurious_d_resp", d_resp, exp_d_resp);
    check("spurious_no_mreq", m_reqcyc, 0);
    repeat (40) begin
      want = 2'($urandom_range(1, 3));
      txn(want[0], want[1], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom), 0, {$urandom, $urandom}, 13'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
